// File: rtl/aes_pkg.sv
// Shared AES types, tables and byte-wise GF(2^8) helpers for the iterative decryptor.
// Blocks are 128-bit vectors with byte 0 in bits [127:120] (FIPS-197 order), column-major.
package aes_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYEXP,
    S_READY,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Round constants for rounds 1..10; any other index yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // One AES-128 key-schedule step: next 4-word round key from the previous one.
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    // RotWord then SubWord, rcon folded into the leading byte
    t  = {SBOX[w3[23:16]] ^ rc, SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[127-8*(4*c+1) -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[127-8*(4*c+2) -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[127-8*(4*c+3) -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round, shared by all ten decryption rounds.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] st_next
);

  logic [127:0] keyed;

  // InvShiftRows, InvSubBytes, AddRoundKey; InvMixColumns skipped in the final round
  always_comb begin
    keyed   = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
    st_next = last ? keyed : inv_mix_columns(keyed);
  end

endmodule

// File: rtl/aes128_dec_sequencer.sv
// Iterative AES-128 decryptor: expands the key once into an 11-entry store, then
// runs one whitening cycle plus ten inverse rounds per block through a single datapath.
// Block byte 0 occupies bits [127:120] (FIPS-197 order).
module aes128_dec_sequencer
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] ct_in,
  input  logic         ct_valid,
  output logic         ct_ready,
  output logic [127:0] pt_out,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic         busy,
  output logic         key_loaded
);

  generate
    if (NR != 10) begin : g_nr_check
      $error("aes128_dec_sequencer supports only NR = 10");
    end
  endgenerate

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_t       state, state_nxt;
  logic [127:0] rk [0:10];
  logic [127:0] st;
  logic [3:0]   rcnt;
  logic         key_fire, ct_fire;
  logic [127:0] rk_new, rk_cur, round_out;

  // Key schedule step reads the previous entry; decryption walks the store backwards
  always_comb begin
    rk_new = key_step(rk[rcnt - 4'd1], rcon(rcnt));
    rk_cur = rk[LAST_RND - rcnt];
  end

  aes_inv_round u_inv_round (
    .st      (st),
    .rk      (rk_cur),
    .last    (rcnt == LAST_RND),
    .st_next (round_out)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake outputs; key load wins over ciphertext in READY
  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    ct_ready  = 1'b0;
    pt_valid  = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        key_ready = 1'b1;
      end
      S_KEYEXP: begin
        busy = 1'b1;
        if (rcnt == LAST_RND) state_nxt = S_READY;
      end
      S_READY: begin
        key_ready = 1'b1;
        ct_ready  = !key_valid;
      end
      S_ROUND: begin
        busy = 1'b1;
        if (rcnt == LAST_RND) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b1;
        pt_valid = 1'b1;
        if (pt_ready) state_nxt = S_READY;
      end
      default: state_nxt = S_IDLE;
    endcase
    key_fire = key_valid && key_ready;
    ct_fire  = ct_valid && ct_ready;
    if (key_fire)     state_nxt = S_KEYEXP;
    else if (ct_fire) state_nxt = S_ROUND;
  end

  // Key store, block state, round counter and key-valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) rk[i] <= '0;
      st         <= '0;
      rcnt       <= 4'd0;
      key_loaded <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_READY: begin
          if (key_fire) begin
            rk[0]      <= key_in;
            rcnt       <= 4'd1;
            key_loaded <= 1'b0;
          end else if (ct_fire) begin
            st   <= ct_in ^ rk[10];
            rcnt <= 4'd1;
          end else begin
            rcnt <= 4'd0;
          end
        end
        S_KEYEXP: begin
          rk[rcnt] <= rk_new;
          if (rcnt == LAST_RND) begin
            rcnt       <= 4'd0;
            key_loaded <= 1'b1;
          end else begin
            rcnt <= rcnt + 4'd1;
          end
        end
        S_ROUND: begin
          st   <= round_out;
          rcnt <= rcnt + 4'd1;
        end
        S_DONE: begin
          if (pt_ready) rcnt <= 4'd0;
        end
        default: rcnt <= 4'd0;
      endcase
    end
  end

  assign pt_out = st;

endmodule

// File: tb/tb_aes128_dec_sequencer.sv
// Directed bench for aes128_dec_sequencer using FIPS-197 and SP 800-38A ECB vectors.
module tb_aes128_dec_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] ct_in;
  logic         ct_valid;
  logic         ct_ready;
  logic [127:0] pt_out;
  logic         pt_valid;
  logic         pt_ready;
  logic         busy;
  logic         key_loaded;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic [127:0] ecb_ct [4] = '{
    128'h3ad77bb40d7a3660a89ecaf32466ef97,
    128'hf5d3d58503b9699de785895a96fdbaaf,
    128'h43b1cd7f598ece23881b00e3ed030688,
    128'h7b0c785e27e8ad3f8223207104725dd4
  };
  logic [127:0] ecb_pt [4] = '{
    128'h6bc1bee22e409f96e93d7e117393172a,
    128'hae2d8a571e03ac9c9eb76fac45af8e51,
    128'h30c81c46a35ce411e5fbc1191a0a52ef,
    128'hf69f2445df4f9b17ad2b417be66c3710
  };

  aes128_dec_sequencer #(.NR(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .ct_in      (ct_in),
    .ct_valid   (ct_valid),
    .ct_ready   (ct_ready),
    .pt_out     (pt_out),
    .pt_valid   (pt_valid),
    .pt_ready   (pt_ready),
    .busy       (busy),
    .key_loaded (key_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a key and return the cycle count right after its handshake edge.
  task automatic load_key(input logic [127:0] k, output int hs);
    int b;
    key_in = k;
    key_valid = 1'b1;
    b = 0;
    while (!key_ready && b < 50) begin tick(); b++; end
    if (!key_ready) begin
      n_vec++; n_err++;
      $display("FAIL load_key_timeout: key_ready=%b required 1", key_ready);
    end
    @(posedge clk);
    #1;
    hs = cyc;
    key_valid = 1'b0;
  endtask

  // Expansion occupies 10 cycles; key_loaded rises after the tenth edge.
  task automatic check_keyexp(input string name);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 9) begin
        n_vec++;
        if (key_loaded !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s_keyexp9: key_loaded=%b busy=%b required 0/1", name, key_loaded, busy);
        end
      end
      if (i == 10) begin
        n_vec++;
        if (key_loaded !== 1'b1 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL %s_keyexp10: key_loaded=%b busy=%b required 1/0", name, key_loaded, busy);
        end
      end
    end
  endtask

  task automatic send_ct(input logic [127:0] c, output int hs);
    int b;
    ct_in = c;
    ct_valid = 1'b1;
    b = 0;
    while (!ct_ready && b < 50) begin tick(); b++; end
    if (!ct_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_ct_timeout: ct_ready=%b required 1", ct_ready);
    end
    @(posedge clk);
    #1;
    hs = cyc;
    ct_valid = 1'b0;
  endtask

  // Wait for pt_valid, check data and latency; consumes the block when pt_ready is high.
  task automatic wait_pt(input logic [127:0] exp, input string name, input int hs);
    int b;
    b = 0;
    while (!pt_valid && b < 40) begin tick(); b++; end
    n_vec++;
    if (!pt_valid) begin
      n_err++;
      $display("FAIL %s_pt_timeout: pt_valid=%b required 1", name, pt_valid);
      return;
    end
    if (pt_out !== exp) begin
      n_err++;
      $display("FAIL %s_pt: pt_out=%h required %h", name, pt_out, exp);
    end
    n_vec++;
    if (cyc - hs !== 10) begin
      n_err++;
      $display("FAIL %s_latency: edges after ct handshake=%0d required 10", name, cyc - hs);
    end
    if (pt_ready) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_valid = 1'b0; ct_valid = 1'b0; pt_ready = 1'b0;
    key_in = '0; ct_in = '0;
    tick(); tick();
    n_vec++;
    if ({key_loaded, pt_valid, busy, key_ready, ct_ready} !== 5'b00010) begin
      n_err++;
      $display("FAIL reset_ctrl: kl/pv/busy/kr/cr=%b required 00010",
               {key_loaded, pt_valid, busy, key_ready, ct_ready});
    end
    n_vec++;
    if (pt_out !== 128'h0) begin
      n_err++;
      $display("FAIL reset_pt_out: pt_out=%h required 0", pt_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips_c1();
    int hs;
    load_key(K_C1, hs);
    check_keyexp("c1");
    pt_ready = 1'b1;
    send_ct(CT_C1, hs);
    wait_pt(PT_C1, "c1", hs);
  endtask

  task automatic test_fips_b();
    int hs;
    load_key(K_B, hs);
    check_keyexp("appb");
    n_vec++;
    if (dut.rk[10] !== RK10B) begin
      n_err++;
      $display("FAIL appb_rk10: rk10=%h required %h", dut.rk[10], RK10B);
    end
    pt_ready = 1'b1;
    send_ct(CT_B, hs);
    wait_pt(PT_B, "appb", hs);
  endtask

  task automatic test_backpressure();
    int hs, rel;
    pt_ready = 1'b0;
    send_ct(CT_B, hs);
    wait_pt(PT_B, "bp", hs);
    ct_in = ecb_ct[0];
    ct_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if (pt_valid !== 1'b1 || pt_out !== PT_B || ct_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_stall%0d: pv=%b cr=%b pt_out=%h required 1/0/%h",
                 i, pt_valid, ct_ready, pt_out, PT_B);
      end
    end
    pt_ready = 1'b1;
    tick();
    rel = cyc;
    n_vec++;
    if (pt_valid !== 1'b0 || ct_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: pv=%b cr=%b required 0/1", pt_valid, ct_ready);
    end
    send_ct(ecb_ct[0], hs);
    n_vec++;
    if (hs - rel !== 1) begin
      n_err++;
      $display("FAIL bp_next_ct: ct accepted %0d edges after release required 1", hs - rel);
    end
    wait_pt(ecb_pt[0], "bp_next", hs);
  endtask

  task automatic test_collision();
    int khs, hs;
    key_in = K_C1; key_valid = 1'b1;
    ct_in = CT_C1; ct_valid = 1'b1;
    #1;
    n_vec++;
    if (ct_ready !== 1'b0 || key_ready !== 1'b1) begin
      n_err++;
      $display("FAIL coll_ready: cr=%b kr=%b required 0/1", ct_ready, key_ready);
    end
    tick();
    khs = cyc;
    key_valid = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || key_loaded !== 1'b0 || ct_ready !== 1'b0) begin
      n_err++;
      $display("FAIL coll_keyexp: busy=%b kl=%b cr=%b required 1/0/0", busy, key_loaded, ct_ready);
    end
    send_ct(CT_C1, hs);
    n_vec++;
    if (hs - khs !== 11) begin
      n_err++;
      $display("FAIL coll_ct_after_rekey: ct accepted %0d edges after key required 11", hs - khs);
    end
    wait_pt(PT_C1, "coll", hs);
  endtask

  task automatic test_reset_mid_round();
    int hs;
    send_ct(CT_C1, hs);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    n_vec++;
    if ({key_ready, busy, key_loaded, pt_valid, ct_ready} !== 5'b10000) begin
      n_err++;
      $display("FAIL midrst_ctrl: kr/busy/kl/pv/cr=%b required 10000",
               {key_ready, busy, key_loaded, pt_valid, ct_ready});
    end
    n_vec++;
    if (pt_out !== 128'h0) begin
      n_err++;
      $display("FAIL midrst_pt_out: pt_out=%h required 0", pt_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int hs, prev;
    load_key(K_B, hs);
    check_keyexp("b2b");
    pt_ready = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      send_ct(ecb_ct[k], hs);
      if (k > 0) begin
        n_vec++;
        if (hs - prev !== 12) begin
          n_err++;
          $display("FAIL b2b_interval%0d: %0d cycles required 12", k, hs - prev);
        end
      end
      prev = hs;
      wait_pt(ecb_pt[k], $sformatf("b2b%0d", k), hs);
    end
  endtask

  initial begin
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_backpressure();
    test_collision();
    test_reset_mid_round();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
